// File: rtl/axi_config_regfile.sv
// axi_config_regfile
// Configuration register bank fed by a single-cycle write stream. It drives
// every register in parallel to the datapath, pulses a per-register write
// event and serves a single-cycle read port with read-before-write
// semantics. Out-of-window accesses are tallied in a saturating 8-bit
// error counter.
module axi_config_regfile #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int REG_COUNT  = 16,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = {ADDR_WIDTH{1'b0}},
    parameter logic [REG_COUNT*DATA_WIDTH-1:0] RESET_VALUES = {(REG_COUNT*DATA_WIDTH){1'b0}},
    parameter logic [REG_COUNT*DATA_WIDTH-1:0] SELF_CLEAR_MASK = {(REG_COUNT*DATA_WIDTH){1'b0}}
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            wr,
    input  logic [ADDR_WIDTH-1:0]           waddr,
    input  logic [DATA_WIDTH-1:0]           wdata,
    input  logic                            rd,
    input  logic [ADDR_WIDTH-1:0]           raddr,
    output logic [DATA_WIDTH-1:0]           rdata,
    output logic                            rdata_valid,
    output logic [REG_COUNT*DATA_WIDTH-1:0] regs_out,
    output logic [REG_COUNT-1:0]            reg_wr_pulse,
    output logic [7:0]                      err_count,
    input  logic                            err_clear
);

    // Byte-offset bits dropped from the address; misaligned accesses
    // therefore land on the containing word.
    localparam int BYTE_SHIFT = $clog2(DATA_WIDTH / 8);
    localparam logic [ADDR_WIDTH-1:0] REG_COUNT_A = ADDR_WIDTH'(REG_COUNT);

    // One-hot register select for an address; all zeros when the address
    // lies below the base or beyond the last register. The subtraction is
    // done at address width, so addresses below the base wrap and are
    // rejected by the explicit lower-bound check.
    function automatic logic [REG_COUNT-1:0] decode_sel(input logic [ADDR_WIDTH-1:0] addr);
        logic [ADDR_WIDTH-1:0] index_v;
        logic [REG_COUNT-1:0]  sel_v;
        index_v = (addr - BASE_ADDR) >> BYTE_SHIFT;
        sel_v   = {REG_COUNT{1'b0}};
        if ((addr >= BASE_ADDR) && (index_v < REG_COUNT_A)) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                sel_v[i] = (index_v == ADDR_WIDTH'(i));
            end
        end else begin
            sel_v = {REG_COUNT{1'b0}};
        end
        return sel_v;
    endfunction

    logic [DATA_WIDTH-1:0] regs_r [REG_COUNT];
    logic [DATA_WIDTH-1:0] rdata_r;
    logic                  rdata_valid_r;
    logic [REG_COUNT-1:0]  reg_wr_pulse_r;
    logic [7:0]            err_count_r;

    logic [REG_COUNT-1:0]  wr_sel_s;
    logic [REG_COUNT-1:0]  rd_sel_s;
    logic                  wr_miss_s;
    logic                  rd_miss_s;
    logic [DATA_WIDTH-1:0] rd_word_s;
    logic [1:0]            err_events_s;
    logic [8:0]            err_sum_s;
    logic [7:0]            err_next_s;

    // Address decode for both ports, gated by their strobes.
    always_comb begin
        wr_sel_s  = {REG_COUNT{1'b0}};
        rd_sel_s  = {REG_COUNT{1'b0}};
        wr_miss_s = 1'b0;
        rd_miss_s = 1'b0;
        if (wr) begin
            wr_sel_s  = decode_sel(waddr);
            wr_miss_s = (wr_sel_s == {REG_COUNT{1'b0}});
        end else begin
            wr_sel_s  = {REG_COUNT{1'b0}};
            wr_miss_s = 1'b0;
        end
        if (rd) begin
            rd_sel_s  = decode_sel(raddr);
            rd_miss_s = (rd_sel_s == {REG_COUNT{1'b0}});
        end else begin
            rd_sel_s  = {REG_COUNT{1'b0}};
            rd_miss_s = 1'b0;
        end
    end

    // AND-OR read mux over the pre-write register contents; zero on a miss.
    always_comb begin
        rd_word_s = {DATA_WIDTH{1'b0}};
        for (int i = 0; i < REG_COUNT; i++) begin
            if (rd_sel_s[i]) begin
                rd_word_s = rd_word_s | regs_r[i];
            end else begin
                rd_word_s = rd_word_s;
            end
        end
    end

    // Next error count: add this cycle's 0..2 events with saturation, or
    // restart from the event count when a clear is requested.
    always_comb begin
        err_events_s = {1'b0, wr_miss_s} + {1'b0, rd_miss_s};
        err_sum_s    = {1'b0, err_count_r} + {7'd0, err_events_s};
        err_next_s   = err_count_r;
        if (err_clear) begin
            err_next_s = {6'd0, err_events_s};
        end else if (err_sum_s > 9'd255) begin
            err_next_s = 8'd255;
        end else begin
            err_next_s = err_sum_s[7:0];
        end
    end

    // Register storage: a write loads the full word, otherwise the
    // self-clearing bits are dropped back to zero every cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                regs_r[i] <= RESET_VALUES[i*DATA_WIDTH +: DATA_WIDTH]
                             & ~SELF_CLEAR_MASK[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end else begin
            for (int i = 0; i < REG_COUNT; i++) begin
                if (wr_sel_s[i]) begin
                    regs_r[i] <= wdata;
                end else begin
                    regs_r[i] <= regs_r[i] & ~SELF_CLEAR_MASK[i*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    // Write event pulses, read response and error counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            reg_wr_pulse_r <= {REG_COUNT{1'b0}};
            rdata_r        <= {DATA_WIDTH{1'b0}};
            rdata_valid_r  <= 1'b0;
            err_count_r    <= 8'd0;
        end else begin
            reg_wr_pulse_r <= wr_sel_s;
            rdata_valid_r  <= rd;
            err_count_r    <= err_next_s;
            if (rd) begin
                rdata_r <= rd_word_s;
            end else begin
                rdata_r <= rdata_r;
            end
        end
    end

    // Flatten the register array onto the parallel output bus.
    always_comb begin
        regs_out = {(REG_COUNT*DATA_WIDTH){1'b0}};
        for (int i = 0; i < REG_COUNT; i++) begin
            regs_out[i*DATA_WIDTH +: DATA_WIDTH] = regs_r[i];
        end
    end

    assign rdata        = rdata_r;
    assign rdata_valid  = rdata_valid_r;
    assign reg_wr_pulse = reg_wr_pulse_r;
    assign err_count    = err_count_r;

endmodule

// File: tb/tb_axi_config_regfile.sv
// Self-checking bench for axi_config_regfile: directed vector table,
// hand-written reset/saturation sequences and random traffic, all compared
// against a word-array reference model kept in the bench.
module tb_axi_config_regfile;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int RC = 16;
    localparam logic [31:0]  BASE = 32'h0000_0100;
    localparam logic [511:0] RV   = 512'hA5A5_0000 << 64;
    localparam logic [511:0] SCM  = 512'h1 << 32;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           wr = 1'b0;
    logic [31:0]    waddr = 32'h0;
    logic [31:0]    wdata = 32'h0;
    logic           rd = 1'b0;
    logic [31:0]    raddr = 32'h0;
    logic [31:0]    rdata;
    logic           rdata_valid;
    logic [511:0]   regs_out;
    logic [15:0]    reg_wr_pulse;
    logic [7:0]     err_count;
    logic           err_clear = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    axi_config_regfile #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .REG_COUNT(RC),
        .BASE_ADDR(BASE), .RESET_VALUES(RV), .SELF_CLEAR_MASK(SCM)
    ) dut (
        .clk(clk), .rst(rst), .wr(wr), .waddr(waddr), .wdata(wdata),
        .rd(rd), .raddr(raddr), .rdata(rdata), .rdata_valid(rdata_valid),
        .regs_out(regs_out), .reg_wr_pulse(reg_wr_pulse),
        .err_count(err_count), .err_clear(err_clear)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [31:0] m_regs [RC];
    logic [15:0] m_pulse;
    logic [31:0] m_rdata;
    logic        m_valid;
    int          m_err;

    function automatic int idx_of(input logic [31:0] a);
        logic [31:0] off;
        if (a < BASE) return -1;
        off = (a - BASE) / 32'd4;
        if (off >= 32'd16) return -1;
        return int'(off);
    endfunction

    function automatic logic [511:0] model_flat();
        logic [511:0] f;
        f = '0;
        for (int k = 0; k < RC; k++) f[k*32 +: 32] = m_regs[k];
        return f;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < RC; k++) m_regs[k] = RV[k*32 +: 32] & ~SCM[k*32 +: 32];
        m_pulse = 16'h0;
        m_rdata = 32'h0;
        m_valid = 1'b0;
        m_err   = 0;
    endtask

    task automatic model_step(input logic w, input logic [31:0] wa, input logic [31:0] wd,
                              input logic r, input logic [31:0] ra, input logic c);
        int wi;
        int ri;
        int ev;
        wi = idx_of(wa);
        ri = idx_of(ra);
        m_valid = r;
        if (r) m_rdata = (ri >= 0) ? m_regs[ri] : 32'h0;
        for (int k = 0; k < RC; k++) m_regs[k] = m_regs[k] & ~SCM[k*32 +: 32];
        m_pulse = 16'h0;
        if (w && wi >= 0) begin
            m_regs[wi] = wd;
            m_pulse[wi] = 1'b1;
        end
        ev = ((w && wi < 0) ? 1 : 0) + ((r && ri < 0) ? 1 : 0);
        if (c) m_err = ev;
        else   m_err = (m_err + ev > 255) ? 255 : m_err + ev;
    endtask

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, ".regs_out"},     regs_out, model_flat());
        check({tag, ".reg_wr_pulse"}, {496'h0, reg_wr_pulse}, {496'h0, m_pulse});
        check({tag, ".rdata_valid"},  {511'h0, rdata_valid}, {511'h0, m_valid});
        check({tag, ".rdata"},        {480'h0, rdata}, {480'h0, m_rdata});
        check({tag, ".err_count"},    {504'h0, err_count}, 512'(m_err));
    endtask

    // One clock of stimulus, model update at the edge, compare #1 later.
    task automatic drive(input string tag, input logic w, input logic [31:0] wa, input logic [31:0] wd,
                         input logic r, input logic [31:0] ra, input logic c);
        wr = w; waddr = wa; wdata = wd; rd = r; raddr = ra; err_clear = c;
        @(posedge clk);
        model_step(w, wa, wd, r, ra, c);
        #1;
        wr = 1'b0; rd = 1'b0; err_clear = 1'b0;
        check_model(tag);
    endtask

    task automatic do_reset(input logic w, input logic r);
        rst = 1'b1; wr = w; waddr = BASE; wdata = 32'hFFFF_FFFF; rd = r; raddr = BASE;
        @(posedge clk);
        model_reset();
        #1;
        rst = 1'b0; wr = 1'b0; rd = 1'b0;
        check_model("reset");
    endtask

    typedef struct {
        logic        wr;
        logic [31:0] waddr;
        logic [31:0] wdata;
        logic        rd;
        logic [31:0] raddr;
        logic [15:0] exp_pulse;
        logic        exp_valid;
        logic        chk_rd;
        logic [31:0] exp_rdata;
        int          chk_reg;
        logic [31:0] exp_reg;
        logic [7:0]  exp_err;
    } vec_t;

    vec_t tbl [15];

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        //          wr    waddr         wdata         rd    raddr         pulse    vld   chk   rdata          reg exp_reg        err
        tbl[0]  = '{1'b0, 32'h0,        32'h0,        1'b1, 32'h108,      16'h0,    1'b1, 1'b1, 32'hA5A5_0000, 2,  32'hA5A5_0000, 8'd0};
        tbl[1]  = '{1'b1, 32'h100,      32'h11,       1'b0, 32'h0,        16'h1,    1'b0, 1'b0, 32'h0,         0,  32'h11,        8'd0};
        tbl[2]  = '{1'b1, 32'h104,      32'h22,       1'b0, 32'h0,        16'h2,    1'b0, 1'b0, 32'h0,         1,  32'h22,        8'd0};
        tbl[3]  = '{1'b1, 32'h108,      32'h33,       1'b0, 32'h0,        16'h4,    1'b0, 1'b0, 32'h0,         2,  32'h33,        8'd0};
        tbl[4]  = '{1'b1, 32'h10C,      32'h44,       1'b0, 32'h0,        16'h8,    1'b0, 1'b0, 32'h0,         3,  32'h44,        8'd0};
        tbl[5]  = '{1'b1, 32'h114,      32'h7,        1'b0, 32'h0,        16'h20,   1'b0, 1'b0, 32'h0,         5,  32'h7,         8'd0};
        tbl[6]  = '{1'b1, 32'h114,      32'h9,        1'b1, 32'h114,      16'h20,   1'b1, 1'b1, 32'h7,         5,  32'h9,         8'd0};
        tbl[7]  = '{1'b0, 32'h0,        32'h0,        1'b1, 32'h114,      16'h0,    1'b1, 1'b1, 32'h9,         5,  32'h9,         8'd0};
        tbl[8]  = '{1'b0, 32'h0,        32'h0,        1'b0, 32'h0,        16'h0,    1'b0, 1'b1, 32'h9,         5,  32'h9,         8'd0};
        tbl[9]  = '{1'b1, 32'h104,      32'h3,        1'b0, 32'h0,        16'h2,    1'b0, 1'b0, 32'h0,         1,  32'h3,         8'd0};
        tbl[10] = '{1'b0, 32'h0,        32'h0,        1'b0, 32'h0,        16'h0,    1'b0, 1'b0, 32'h0,         1,  32'h2,         8'd0};
        tbl[11] = '{1'b0, 32'h0,        32'h0,        1'b0, 32'h0,        16'h0,    1'b0, 1'b0, 32'h0,         1,  32'h2,         8'd0};
        tbl[12] = '{1'b1, 32'hFC,       32'hDEAD,     1'b1, 32'h140,      16'h0,    1'b1, 1'b1, 32'h0,         0,  32'h11,        8'd2};
        tbl[13] = '{1'b0, 32'h0,        32'h0,        1'b1, 32'h103,      16'h0,    1'b1, 1'b1, 32'h11,        0,  32'h11,        8'd2};
        tbl[14] = '{1'b1, 32'h13F,      32'h5A,       1'b1, 32'h13C,      16'h8000, 1'b1, 1'b1, 32'h0,         15, 32'h5A,        8'd2};

        // Reset state
        repeat (2) @(posedge clk);
        do_reset(1'b0, 1'b0);
        check("reset.reg2", {480'h0, regs_out[95:64]}, {480'h0, 32'hA5A5_0000});

        // Directed vector table
        for (int i = 0; i < 15; i++) begin
            drive($sformatf("vec%0d", i), tbl[i].wr, tbl[i].waddr, tbl[i].wdata,
                  tbl[i].rd, tbl[i].raddr, 1'b0);
            check($sformatf("vec%0d.pulse", i), {496'h0, reg_wr_pulse}, {496'h0, tbl[i].exp_pulse});
            check($sformatf("vec%0d.valid", i), {511'h0, rdata_valid}, {511'h0, tbl[i].exp_valid});
            if (tbl[i].chk_rd)
                check($sformatf("vec%0d.rdata", i), {480'h0, rdata}, {480'h0, tbl[i].exp_rdata});
            check($sformatf("vec%0d.reg", i), {480'h0, regs_out[tbl[i].chk_reg*32 +: 32]},
                  {480'h0, tbl[i].exp_reg});
            check($sformatf("vec%0d.err", i), {504'h0, err_count}, {504'h0, tbl[i].exp_err});
        end

        // Saturation and clear
        do_reset(1'b0, 1'b0);
        for (int i = 0; i < 300; i++) drive("sat", 1'b1, 32'h0, 32'h1234, 1'b0, 32'h0, 1'b0);
        check("sat.err255", {504'h0, err_count}, {504'h0, 8'd255});
        drive("clr1", 1'b1, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1);
        check("clr.err1", {504'h0, err_count}, {504'h0, 8'd1});
        drive("clr2", 1'b1, 32'h200, 32'h0, 1'b1, 32'hF0, 1'b1);
        check("clr.err2", {504'h0, err_count}, {504'h0, 8'd2});
        drive("clr0", 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1);
        check("clr.err0", {504'h0, err_count}, {504'h0, 8'd0});

        // Reset in the middle of traffic discards that cycle's accesses
        drive("pre_rst", 1'b1, 32'h100, 32'hCAFE, 1'b1, 32'h100, 1'b0);
        do_reset(1'b1, 1'b1);
        check("midrst.pulse", {496'h0, reg_wr_pulse}, 512'h0);
        check("midrst.valid", {511'h0, rdata_valid}, 512'h0);
        drive("post_rst", 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
        check("postrst.pulse", {496'h0, reg_wr_pulse}, 512'h0);

        // Random traffic around the address window
        for (int i = 0; i < 600; i++) begin
            drive("rand", 1'($urandom_range(0, 1)), 32'($urandom_range(32'hF0, 32'h14F)), $urandom(),
                  1'($urandom_range(0, 1)), 32'($urandom_range(32'hF0, 32'h14F)),
                  ($urandom_range(0, 15) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
